// File: rtl/bsg_piso_sched_pkg.sv
// bsg_piso_sched_pkg: shared state encoding and id-width helper for the serial scheduler
package bsg_piso_sched_pkg;
  typedef enum logic [0:0] {eIDLE, eTX} state_e;
  function automatic int id_width(input int els);
    return (els == 1) ? 1 : $clog2(els);
  endfunction
endpackage

// File: rtl/bsg_piso_rr_arb.sv
// bsg_piso_rr_arb: combinational round-robin pick starting after the last winner
module bsg_piso_rr_arb #(
  parameter int els_p   = 4,
  parameter int id_w_lp = 2
) (
  input  logic [els_p-1:0]   valid_i,
  input  logic [id_w_lp-1:0] last_i,
  input  logic               en_i,
  output logic [els_p-1:0]   grant_o,
  output logic [id_w_lp-1:0] id_o,
  output logic               v_o
);
  logic               hit;
  logic [id_w_lp-1:0] idx;
  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    id_o = '0;
    for (int i = 1; i <= els_p; i++) begin
      idx = id_w_lp'((int'(last_i) + i) % els_p);
      if (!hit && valid_i[idx]) begin
        hit  = 1'b1;
        id_o = idx;
      end
    end
    v_o     = en_i && hit;
    grant_o = v_o ? els_p'(1) << id_o : '0;
  end
endmodule

// File: rtl/bsg_piso_rr_sched.sv
// bsg_piso_rr_sched: round-robin arbitration of parallel words onto one serial link,
// each frame carrying the winner id (LSB first) followed by its payload (LSB first)
module bsg_piso_rr_sched
  import bsg_piso_sched_pkg::*;
#(
  parameter int els_p   = 4,
  parameter int width_p = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [els_p-1:0]         valid_i,
  input  logic [els_p*width_p-1:0] data_i,
  output logic [els_p-1:0]         yumi_o,
  output logic                     valid_o,
  output logic                     data_o,
  output logic                     frame_start_o,
  input  logic                     yumi_i
);
  localparam int id_w_lp    = id_width(els_p);
  localparam int frame_w_lp = id_w_lp + width_p;
  localparam int ctr_w_lp   = $clog2(frame_w_lp);
  localparam logic [ctr_w_lp-1:0] ctr_last_lp = ctr_w_lp'(frame_w_lp - 1);

  state_e                  state_q, state_d;
  logic [ctr_w_lp-1:0]     ctr_q, ctr_d;
  logic [frame_w_lp-1:0]   frame_q, frame_d;
  logic [id_w_lp-1:0]      last_q, last_d, id;
  logic                    grant_v, done, grant_en;

  assign done = (state_q == eTX) && (ctr_q == ctr_last_lp) && yumi_i;
  // gated by reset so no accept can leak out while the block is held in reset
  assign grant_en = reset_n_i && ((state_q == eIDLE) || done);

  bsg_piso_rr_arb #(.els_p(els_p), .id_w_lp(id_w_lp)) arb (
    .valid_i(valid_i),
    .last_i (last_q),
    .en_i   (grant_en),
    .grant_o(yumi_o),
    .id_o   (id),
    .v_o    (grant_v)
  );

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    frame_d = frame_q;
    last_d  = last_q;
    if (grant_v) begin
      state_d = eTX;
      ctr_d   = '0;
      frame_d = {data_i[int'(id)*width_p +: width_p], id};
      last_d  = id;
    end else if (done) state_d = eIDLE;
    else if ((state_q == eTX) && yumi_i && (ctr_q != ctr_last_lp)) ctr_d = ctr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= eIDLE;
      ctr_q   <= '0;
      frame_q <= '0;
      last_q  <= id_w_lp'(els_p - 1);
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      frame_q <= frame_d;
      last_q  <= last_d;
    end
  end

  assign valid_o       = (state_q == eTX);
  assign data_o        = frame_q[ctr_q];
  assign frame_start_o = valid_o && (ctr_q == '0);
endmodule
